seven_seg_scanner: RTL

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/vending_display_pkg.sv | 59 +++++
 rtl/bin2bcd_seq.sv | 91 +++++++++
 rtl/seven_seg_scanner.sv | 89 ++++++++
 3 files changed

// File: rtl/vending_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vending_display_pkg
//  Description : Shared constants, segment patterns and helpers for the
//                four-digit seven-segment scanner and its BCD converter.
//  Revision    : 1.0  initial release
// ============================================================================
package vending_display_pkg;

   localparam int DIGITS      = 4;
   localparam int VALUE_W     = 14;
   localparam int MAX_DISPLAY = 9999;
   localparam int BCD_W       = 4 * DIGITS;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] c_seg_0     = 7'h40;
   localparam logic [6:0] c_seg_1     = 7'h79;
   localparam logic [6:0] c_seg_2     = 7'h24;
   localparam logic [6:0] c_seg_3     = 7'h30;
   localparam logic [6:0] c_seg_4     = 7'h19;
   localparam logic [6:0] c_seg_5     = 7'h12;
   localparam logic [6:0] c_seg_6     = 7'h02;
   localparam logic [6:0] c_seg_7     = 7'h78;
   localparam logic [6:0] c_seg_8     = 7'h00;
   localparam logic [6:0] c_seg_9     = 7'h10;
   localparam logic [6:0] c_seg_dash  = 7'h3F;
   localparam logic [6:0] c_seg_blank = 7'h7F;

   // Converter FSM encoding
   localparam logic [0:0] c_st_idle    = 1'b0;
   localparam logic [0:0] c_st_convert = 1'b1;

   // Index of the final shift iteration (one iteration per input bit)
   localparam logic [3:0] c_last_iter = 4'(VALUE_W - 1);

   // Map a BCD digit to its segment pattern; non-decimal codes show blank
   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      case (digit)
         4'd0:    return c_seg_0;
         4'd1:    return c_seg_1;
         4'd2:    return c_seg_2;
         4'd3:    return c_seg_3;
         4'd4:    return c_seg_4;
         4'd5:    return c_seg_5;
         4'd6:    return c_seg_6;
         4'd7:    return c_seg_7;
         4'd8:    return c_seg_8;
         4'd9:    return c_seg_9;
         default: return c_seg_blank;
      endcase
   endfunction

   // Double-dabble column correction applied before each shift
   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? (d + 4'd3) : d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential shift-add-3 binary to BCD converter, one input
//                bit per clock. done pulses for one cycle once bcd is final.
//  Revision    : 1.0  initial release
// ============================================================================
module bin2bcd_seq
   import vending_display_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [VALUE_W-1:0] value,
   output logic               busy,
   output logic               done,
   output logic [BCD_W-1:0]   bcd,
   output logic               ovf
);

   logic [0:0]         r_state;
   logic [0:0]         w_state_nxt;
   logic [3:0]         r_cnt;
   logic [VALUE_W-1:0] r_bin;
   logic [BCD_W-1:0]   r_bcd;
   logic               r_ovf;
   logic               r_done;
   logic               w_accept;
   logic               w_shift_en;
   logic [2:0]         w_adj3;
   logic [BCD_W-1:0]   w_bcd_nxt;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= c_st_idle;
      else          r_state <= w_state_nxt;
   end

   // Next-state: a start is refused while the done pulse is still showing busy
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle:    if (start && !r_done)        w_state_nxt = c_st_convert;
         c_st_convert: if (r_cnt == c_last_iter)    w_state_nxt = c_st_idle;
         default:                                   w_state_nxt = c_st_idle;
      endcase
   end

   // Outputs: busy spans the 14 shift cycles, ending with the done cycle
   always_comb begin
      w_accept   = (r_state == c_st_idle) && start && !r_done;
      w_shift_en = (r_state == c_st_convert);
      busy       = (w_shift_en && (r_cnt != 4'd0)) || r_done;
      done       = r_done;
      bcd        = r_bcd;
      ovf        = r_ovf;
   end

   // Correct each column, then shift in the next binary bit. Only the low
   // three bits of the top column survive the shift.
   always_comb begin
      w_adj3    = (r_bcd[15:12] >= 4'd5) ? (r_bcd[14:12] + 3'd3) : r_bcd[14:12];
      w_bcd_nxt = {w_adj3, add3(r_bcd[11:8]), add3(r_bcd[7:4]),
                   add3(r_bcd[3:0]), r_bin[VALUE_W-1]};
   end

   // Datapath: capture on accept, then one shift per cycle while converting
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt  <= 4'd0;
         r_bin  <= '0;
         r_bcd  <= '0;
         r_ovf  <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_shift_en && (r_cnt == c_last_iter);
         if (w_accept) begin
            r_bin <= value;
            r_bcd <= '0;
            r_cnt <= 4'd0;
            r_ovf <= (value > VALUE_W'(MAX_DISPLAY));
         end else if (w_shift_en) begin
            r_bin <= {r_bin[VALUE_W-2:0], 1'b0};
            r_bcd <= w_bcd_nxt;
            r_cnt <= r_cnt + 4'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scanner
//  Description : Four-digit multiplexed seven-segment driver. Converts a
//                loaded binary value to BCD and scans the digits continuously.
//  Revision    : 1.0  initial release
// ============================================================================
module seven_seg_scanner
   import vending_display_pkg::*;
#(
   parameter int SCAN_DIV      = 100000,
   parameter bit BLANK_LEADING = 1'b1
)(
   input  logic               clk,
   input  logic               reset_n,
   input  logic [VALUE_W-1:0] value,
   input  logic               load,
   output logic               busy,
   output logic               overflow,
   output logic [6:0]         seg,
   output logic [DIGITS-1:0]  an
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [CNT_W-1:0] r_scan_cnt;
   logic [1:0]       r_digit_idx;
   logic [BCD_W-1:0] r_disp;
   logic             r_ovf;
   logic             w_done;
   logic             w_conv_ovf;
   logic [BCD_W-1:0] w_bcd;
   logic [3:0]       w_digit;
   logic [3:0]       w_lead_zero;

   bin2bcd_seq u_bin2bcd (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (load),
      .value   (value),
      .busy    (busy),
      .done    (w_done),
      .bcd     (w_bcd),
      .ovf     (w_conv_ovf)
   );

   // Scan counter: advance to the next digit every SCAN_DIV cycles
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_scan_cnt  <= '0;
         r_digit_idx <= 2'd0;
      end else if (r_scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
         r_scan_cnt  <= '0;
         r_digit_idx <= r_digit_idx + 2'd1;
      end else begin
         r_scan_cnt  <= r_scan_cnt + CNT_W'(1);
      end
   end

   // Display latch: take the finished BCD word only on done, never partials
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_disp <= '0;
         r_ovf  <= 1'b0;
      end else if (w_done) begin
         r_disp <= w_bcd;
         r_ovf  <= w_conv_ovf;
      end
   end

   // Digit mux, leading-zero blanking and segment decode for the active digit
   always_comb begin
      w_digit        = r_disp[{r_digit_idx, 2'b00} +: 4];
      w_lead_zero[3] = (r_disp[15:12] == 4'd0);
      w_lead_zero[2] = w_lead_zero[3] && (r_disp[11:8] == 4'd0);
      w_lead_zero[1] = w_lead_zero[2] && (r_disp[7:4] == 4'd0);
      w_lead_zero[0] = 1'b0;
      an             = ~(4'b0001 << r_digit_idx);
      overflow       = r_ovf;
      if (r_ovf)
         seg = c_seg_dash;
      else if (BLANK_LEADING && w_lead_zero[r_digit_idx])
         seg = c_seg_blank;
      else
         seg = seg_decode(w_digit);
   end

endmodule
`default_nettype wire
